// File: rtl/ds_operand_unit_pkg.sv
// Shared widths, bus layouts and operand-match helpers for the decode-stage operand unit.
package ds_operand_unit_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int ES_FWD_BUS_WD   = 39;
    localparam int MS_FWD_BUS_WD   = 38;
    localparam int WS_TO_ID_BUS_WD = 38;
    localparam int REG_AW          = 5;

    typedef enum logic [1:0] {
        SRC_GPR,
        SRC_ES,
        SRC_MS,
        SRC_WS
    } fwd_src_e;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] dest;
        logic [31:0]       value;
    } wb_bus_t;

    typedef struct packed {
        logic              is_load;
        logic              we;
        logic [REG_AW-1:0] dest;
        logic [31:0]       value;
    } es_bus_t;

    function automatic logic reg_match(input logic we, input logic [REG_AW-1:0] dest,
                                       input logic [REG_AW-1:0] raddr, input logic used);
        return we && (dest == raddr) && (raddr != '0) && used;
    endfunction

    function automatic fwd_src_e fwd_pick(input logic es_hit, input logic ms_hit, input logic ws_hit);
        if (es_hit)      return SRC_ES;
        else if (ms_hit) return SRC_MS;
        else if (ws_hit) return SRC_WS;
        else             return SRC_GPR;
    endfunction

endpackage

// File: rtl/ds_operand_unit_if.sv
// IF->DS->EX pipeline handshake and the latched instruction/pc seen by the external decoder.
interface ds_operand_unit_if;
    import ds_operand_unit_pkg::*;

    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       ds_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic                       br_cancel;
    logic [31:0]                ds_inst;
    logic [31:0]                ds_pc;

    modport master (
        output fs_to_ds_valid, fs_to_ds_bus, es_allowin, br_cancel,
        input  ds_allowin, ds_to_es_valid, ds_inst, ds_pc
    );

    modport slave (
        input  fs_to_ds_valid, fs_to_ds_bus, es_allowin, br_cancel,
        output ds_allowin, ds_to_es_valid, ds_inst, ds_pc
    );

endinterface

// File: rtl/ds_operand_unit_regfile.sv
// GPR file: two asynchronous read ports, one synchronous write port, r0 hard-wired to zero.
module ds_operand_unit_regfile
    import ds_operand_unit_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  wb_bus_t           wr,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [31:0]       rdata1,
    output logic [31:0]       rdata2
);

    logic [31:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (wr.we && (wr.dest != '0)) begin
            regs[wr.dest] <= wr.value;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ds_operand_unit.sv
// Decode-stage operand unit: fs->ds register, GPR reads, EX/MEM/WB forwarding and load-use stall.
module ds_operand_unit
    import ds_operand_unit_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int NREG   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    ds_operand_unit_if.slave           pipe,
    input  logic [REG_AW-1:0]          raddr1,
    input  logic [REG_AW-1:0]          raddr2,
    input  logic                       src1_used,
    input  logic                       src2_used,
    output logic [31:0]                rdata1,
    output logic [31:0]                rdata2,
    input  logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
    input  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [WS_TO_ID_BUS_WD-1:0] ws_to_id_bus,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus
);

    logic                       ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] ds_bus;
    logic                       ds_ready_go;
    logic                       stall;
    logic                       hazard;

    es_bus_t es;
    wb_bus_t ms;
    wb_bus_t ws;
    wb_bus_t rf_wr;

    logic [31:0] gpr1, gpr2;
    fwd_src_e    src1, src2;

    assign es    = es_bus_t'(es_fwd_bus);
    assign ms    = wb_bus_t'(ms_fwd_bus);
    assign ws    = wb_bus_t'(ws_to_id_bus);
    assign rf_wr = wb_bus_t'(ws_to_rf_bus);

    ds_operand_unit_regfile #(.NREG(NREG)) u_regfile (
        .clk    (clk),
        .wr     (rf_wr),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (gpr1),
        .rdata2 (gpr2)
    );

    // Forward selection ignores srcN_used so rdata tracks the newest value even for unused sources.
    always_comb begin
        src1 = SRC_GPR;
        src2 = SRC_GPR;
        if (FWD_EN != 0) begin
            src1 = fwd_pick(reg_match(es.we, es.dest, raddr1, 1'b1),
                            reg_match(ms.we, ms.dest, raddr1, 1'b1),
                            reg_match(ws.we, ws.dest, raddr1, 1'b1));
            src2 = fwd_pick(reg_match(es.we, es.dest, raddr2, 1'b1),
                            reg_match(ms.we, ms.dest, raddr2, 1'b1),
                            reg_match(ws.we, ws.dest, raddr2, 1'b1));
        end
    end

    always_comb begin
        unique case (src1)
            SRC_ES:  rdata1 = es.value;
            SRC_MS:  rdata1 = ms.value;
            SRC_WS:  rdata1 = ws.value;
            default: rdata1 = gpr1;
        endcase
        unique case (src2)
            SRC_ES:  rdata2 = es.value;
            SRC_MS:  rdata2 = ms.value;
            SRC_WS:  rdata2 = ws.value;
            default: rdata2 = gpr2;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = es.is_load && (reg_match(es.we, es.dest, raddr1, src1_used) ||
                                    reg_match(es.we, es.dest, raddr2, src2_used));
        end else begin
            hazard = reg_match(es.we, es.dest, raddr1, src1_used) ||
                     reg_match(es.we, es.dest, raddr2, src2_used) ||
                     reg_match(ms.we, ms.dest, raddr1, src1_used) ||
                     reg_match(ms.we, ms.dest, raddr2, src2_used) ||
                     reg_match(ws.we, ws.dest, raddr1, src1_used) ||
                     reg_match(ws.we, ws.dest, raddr2, src2_used);
        end
    end

    assign stall               = ds_valid && hazard;
    assign ds_ready_go         = !stall;
    assign pipe.ds_allowin     = !ds_valid || (ds_ready_go && pipe.es_allowin);
    assign pipe.ds_to_es_valid = ds_valid && ds_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
        end else if (pipe.br_cancel) begin
            ds_valid <= 1'b0;
        end else if (pipe.ds_allowin) begin
            ds_valid <= pipe.fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (pipe.fs_to_ds_valid && pipe.ds_allowin) begin
            ds_bus <= pipe.fs_to_ds_bus;
        end
    end

    assign pipe.ds_pc   = ds_bus[63:32];
    assign pipe.ds_inst = ds_bus[31:0];

endmodule

// File: tb/tb_ds_operand_unit.sv
// Scoreboard bench for ds_operand_unit: forwarding (dut 0) and no-forwarding (dut 1) instances share stimulus.
module tb_ds_operand_unit;
  import ds_operand_unit_pkg::*;

  typedef enum int {K_VALID, K_ALLOWIN, K_RD1, K_RD2, K_PC} kind_e;

  typedef struct {
    string       name;
    int          dut;
    kind_e       kind;
    logic [31:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_valid, es_allowin, br_cancel;
  logic [63:0] fs_bus;
  logic [4:0]  raddr1, raddr2;
  logic        src1_used, src2_used;
  logic [38:0] es_bus;
  logic [37:0] ms_bus, ws_id_bus, ws_rf_bus;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ds_operand_unit_if bus_fwd ();
  ds_operand_unit_if bus_nofwd ();

  assign bus_fwd.fs_to_ds_valid   = fs_valid;
  assign bus_fwd.fs_to_ds_bus     = fs_bus;
  assign bus_fwd.es_allowin       = es_allowin;
  assign bus_fwd.br_cancel        = br_cancel;
  assign bus_nofwd.fs_to_ds_valid = fs_valid;
  assign bus_nofwd.fs_to_ds_bus   = fs_bus;
  assign bus_nofwd.es_allowin     = es_allowin;
  assign bus_nofwd.br_cancel      = br_cancel;

  ds_operand_unit #(.FWD_EN(1), .NREG(32)) dut_fwd (
    .clk          (clk),
    .reset        (reset),
    .pipe         (bus_fwd),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .src1_used    (src1_used),
    .src2_used    (src2_used),
    .rdata1       (rd1_a),
    .rdata2       (rd2_a),
    .es_fwd_bus   (es_bus),
    .ms_fwd_bus   (ms_bus),
    .ws_to_id_bus (ws_id_bus),
    .ws_to_rf_bus (ws_rf_bus)
  );

  ds_operand_unit #(.FWD_EN(0), .NREG(32)) dut_nofwd (
    .clk          (clk),
    .reset        (reset),
    .pipe         (bus_nofwd),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .src1_used    (src1_used),
    .src2_used    (src2_used),
    .rdata1       (rd1_b),
    .rdata2       (rd2_b),
    .es_fwd_bus   (es_bus),
    .ms_fwd_bus   (ms_bus),
    .ws_to_id_bus (ws_id_bus),
    .ws_to_rf_bus (ws_rf_bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int dut, input kind_e kind, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.dut  = dut;
    c.kind = kind;
    c.exp  = v;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] observe(input int dut, input kind_e kind);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_VALID:   r = {31'b0, (dut == 0) ? bus_fwd.ds_to_es_valid : bus_nofwd.ds_to_es_valid};
      K_ALLOWIN: r = {31'b0, (dut == 0) ? bus_fwd.ds_allowin : bus_nofwd.ds_allowin};
      K_RD1:     r = (dut == 0) ? rd1_a : rd1_b;
      K_RD2:     r = (dut == 0) ? rd2_a : rd2_b;
      K_PC:      r = (dut == 0) ? bus_fwd.ds_pc : bus_nofwd.ds_pc;
      default:   r = '0;
    endcase
    return r;
  endfunction

  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c   = sb.pop_front();
        act = observe(c.dut, c.kind);
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s (dut%0d): got %h, want %h", c.name, c.dut, act, c.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1; fs_valid = 1'b0; fs_bus = '0; es_allowin = 1'b1; br_cancel = 1'b0;
    raddr1 = '0; raddr2 = '0; src1_used = 1'b0; src2_used = 1'b0;
    es_bus = '0; ms_bus = '0; ws_id_bus = '0; ws_rf_bus = '0;

    // reset state
    step(); step();
    total++;
    if (bus_fwd.ds_allowin !== 1'b1) begin
      bad++;
      $display("FAIL direct_rst_allowin (dut0): got %b", bus_fwd.ds_allowin);
    end
    total++;
    if (bus_nofwd.ds_allowin !== 1'b1) begin
      bad++;
      $display("FAIL direct_rst_allowin (dut1): got %b", bus_nofwd.ds_allowin);
    end
    for (int d = 0; d < 2; d++) begin
      expect_val("rst_valid", d, K_VALID, 32'd0);
      expect_val("rst_allowin", d, K_ALLOWIN, 32'd1);
    end
    reset = 1'b0;

    // GPR write then read; r0 reads zero; read in write cycle returns old value
    ws_rf_bus = {1'b1, 5'd5, 32'h1234_5678};
    step();
    ws_rf_bus = '0; raddr1 = 5'd5; raddr2 = 5'd0; src1_used = 1'b1; src2_used = 1'b1;
    expect_val("gpr_r5", 0, K_RD1, 32'h1234_5678);
    expect_val("gpr_r0", 0, K_RD2, 32'h0);
    expect_val("gpr_r5", 1, K_RD1, 32'h1234_5678);
    step();
    ws_rf_bus = {1'b1, 5'd5, 32'h0000_9999};
    expect_val("gpr_old_in_wr_cycle", 0, K_RD1, 32'h1234_5678);
    step();
    ws_rf_bus = {1'b1, 5'd0, 32'hDEAD_BEEF};
    expect_val("gpr_new_after_wr", 0, K_RD1, 32'h0000_9999);
    step();
    ws_rf_bus = '0; raddr1 = 5'd0;
    expect_val("gpr_r0_after_wr", 0, K_RD1, 32'h0);

    // forward priority ES > MS > WS; unused source still forwards
    step();
    raddr1 = 5'd3; raddr2 = 5'd3; src2_used = 1'b0;
    es_bus    = {1'b0, 1'b1, 5'd3, 32'h0000_000A};
    ms_bus    = {1'b1, 5'd3, 32'h0000_000B};
    ws_id_bus = {1'b1, 5'd3, 32'h0000_000C};
    expect_val("fwd_es", 0, K_RD1, 32'hA);
    expect_val("fwd_es_unused", 0, K_RD2, 32'hA);
    step();
    es_bus = '0;
    expect_val("fwd_ms", 0, K_RD1, 32'hB);
    step();
    ms_bus = '0;
    expect_val("fwd_ws", 0, K_RD1, 32'hC);
    step();
    ws_id_bus = '0; raddr1 = 5'd0; raddr2 = 5'd0;

    // load-use stall for one cycle, then MS forward releases it
    fs_valid = 1'b1; fs_bus = {32'h0000_2000, 32'h0000_0022};
    step();
    fs_bus = {32'h0000_3000, 32'h0000_0033};
    es_bus = {1'b1, 1'b1, 5'd7, 32'h0};
    raddr2 = 5'd7; src2_used = 1'b1; src1_used = 1'b0;
    expect_val("lu_stall_valid", 0, K_VALID, 32'd0);
    expect_val("lu_stall_allowin", 0, K_ALLOWIN, 32'd0);
    expect_val("lu_stall_pc", 0, K_PC, 32'h2000);
    step();
    es_bus = '0; ms_bus = {1'b1, 5'd7, 32'h0000_0055};
    expect_val("lu_release_valid", 0, K_VALID, 32'd1);
    expect_val("lu_release_allowin", 0, K_ALLOWIN, 32'd1);
    expect_val("lu_release_rd2", 0, K_RD2, 32'h55);
    expect_val("lu_hold_pc", 0, K_PC, 32'h2000);
    step();
    ms_bus = '0;
    expect_val("next_fetch_pc", 0, K_PC, 32'h3000);
    expect_val("next_fetch_valid", 0, K_VALID, 32'd1);

    // unused source never stalls; r0 destination never stalls
    fs_bus = {32'h0000_4000, 32'h0000_0044};
    es_bus = {1'b1, 1'b1, 5'd7, 32'h0000_0066};
    raddr2 = 5'd7; src2_used = 1'b0; raddr1 = 5'd0; src1_used = 1'b0;
    expect_val("unused_no_stall", 0, K_VALID, 32'd1);
    expect_val("unused_rd2_fwd", 0, K_RD2, 32'h66);
    step();
    es_bus = {1'b1, 1'b1, 5'd0, 32'h0000_0077};
    raddr1 = 5'd0; raddr2 = 5'd0; src1_used = 1'b1; src2_used = 1'b1;
    fs_valid = 1'b0;
    expect_val("r0_no_stall", 0, K_VALID, 32'd1);
    expect_val("r0_rd1", 0, K_RD1, 32'h0);
    expect_val("r0_rd2", 0, K_RD2, 32'h0);
    expect_val("r0_pc", 0, K_PC, 32'h4000);
    step();
    es_bus = '0;

    // EX backpressure holds DS; branch cancel flushes it
    fs_valid = 1'b1; fs_bus = {32'h0000_5000, 32'h0000_0055};
    step();
    es_allowin = 1'b0; fs_bus = {32'h0000_6000, 32'h0000_0066};
    for (int i = 0; i < 3; i++) begin
      expect_val("bp_valid", 0, K_VALID, 32'd1);
      expect_val("bp_allowin", 0, K_ALLOWIN, 32'd0);
      expect_val("bp_pc", 0, K_PC, 32'h5000);
      step();
    end
    br_cancel = 1'b1;
    step();
    total++;
    if (bus_fwd.ds_to_es_valid !== 1'b0) begin
      bad++;
      $display("FAIL direct_cancel_valid (dut0): got %b", bus_fwd.ds_to_es_valid);
    end
    br_cancel = 1'b0; fs_valid = 1'b0;
    expect_val("cancel_valid", 0, K_VALID, 32'd0);
    expect_val("cancel_allowin", 0, K_ALLOWIN, 32'd1);
    es_allowin = 1'b1;

    // no-forward instance: stall on WS match until it drops, then read GPR
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_val("rst2_valid", 1, K_VALID, 32'd0);
    expect_val("rst2_allowin", 1, K_ALLOWIN, 32'd1);
    fs_valid = 1'b1; fs_bus = {32'h0000_7000, 32'h0000_0077};
    step();
    fs_valid = 1'b0;
    raddr1 = 5'd9; src1_used = 1'b1; raddr2 = 5'd0; src2_used = 1'b0;
    ws_id_bus = {1'b1, 5'd9, 32'h0000_C0DE};
    ws_rf_bus = {1'b1, 5'd9, 32'h0000_C0DE};
    expect_val("nf_ws_stall_valid", 1, K_VALID, 32'd0);
    expect_val("nf_ws_stall_allowin", 1, K_ALLOWIN, 32'd0);
    expect_val("f_ws_no_stall", 0, K_VALID, 32'd1);
    expect_val("f_ws_fwd", 0, K_RD1, 32'h0000_C0DE);
    step();
    expect_val("nf_ws_still_stall", 1, K_VALID, 32'd0);
    step();
    ws_id_bus = '0; ws_rf_bus = '0;
    expect_val("nf_release_valid", 1, K_VALID, 32'd1);
    expect_val("nf_release_rd1", 1, K_RD1, 32'h0000_C0DE);
    expect_val("nf_release_pc", 1, K_PC, 32'h7000);

    // no-forward instance ignores MS value and stalls; forward instance takes it
    fs_valid = 1'b1; fs_bus = {32'h0000_8000, 32'h0000_0088};
    step();
    fs_valid = 1'b0;
    ms_bus = {1'b1, 5'd9, 32'h0000_0BAD};
    expect_val("nf_ms_stall", 1, K_VALID, 32'd0);
    expect_val("nf_ms_no_fwd", 1, K_RD1, 32'h0000_C0DE);
    expect_val("f_ms_fwd", 0, K_RD1, 32'h0000_0BAD);
    expect_val("f_ms_valid", 0, K_VALID, 32'd1);

    // reset while stalled
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_val("rst_mid_stall_valid", 1, K_VALID, 32'd0);
    expect_val("rst_mid_stall_allowin", 1, K_ALLOWIN, 32'd1);
    step();
    ms_bus = '0;

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard not drained: %0d left", sb.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL too few checks executed: %0d", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
